// File: rtl/wb_initiator_pkg.sv
// wb_initiator_pkg
//   Shared types and helpers for the Wishbone classic initiator.
//   - size_t  : request access size encoding (3 is not a legal size)
//   - state_t : initiator FSM states
//   - is_misaligned() : size/address legality check done at acceptance
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Size code 3 has no legal interpretation, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [1:0] size);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// wb_lane_align
//   Combinational byte-lane steering for the Wishbone initiator.
//   Write side: lane select and replicated write data.
//   Read side : shift the addressed lanes down to bit 0, then zero/sign extend.
// Ports
//   addr_lo_i   in  2   byte offset within the word
//   size_i      in  2   access size (size_t encoding)
//   unsigned_i  in  1   1 = zero-extend read data, 0 = sign-extend
//   wdata_i     in  32  LSB-justified write data
//   dat_i       in  32  raw Wishbone read data
//   sel_o       out 4   byte lane select
//   dat_o       out 32  write data replicated across lanes
//   rdata_o     out 32  aligned, extended read data
module wb_lane_align
  import wb_initiator_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = dat_i >> {addr_lo_i, 3'b000};

  always_comb begin
    sel_o   = 4'b0000;
    dat_o   = 32'h0;
    rdata_o = 32'h0;
    case (size_i)
      SIZE_BYTE: begin
        sel_o   = 4'b0001 << addr_lo_i;
        dat_o   = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        sel_o   = 4'b0011 << addr_lo_i;
        dat_o   = {2{wdata_i[15:0]}};
        rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        sel_o   = 4'b1111;
        dat_o   = wdata_i;
        rdata_o = shifted;
      end
      default: begin
        sel_o   = 4'b0000;
        dat_o   = 32'h0;
        rdata_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/wb_initiator.sv
// wb_initiator
//   Wishbone classic initiator: converts a single-outstanding request/response
//   port from the load/store unit into Wishbone cycles on the peripheral fabric.
//   Optional build macro WB_TIMEOUT_EN adds a bus timeout of TIMEOUT_CYCLES.
//
//   state | meaning
//   IDLE  | ready for a request
//   BUS   | cyc/stb asserted, waiting for ack (or timeout)
//   DONE  | one-cycle response pulse
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_*_i / req_ready_o   request handshake and fields
//   resp_valid_o/rdata_o/err_o  response (one-cycle pulse)
//   cyc_o stb_o we_o adr_o dat_o sel_o / dat_i ack_i   Wishbone initiator side
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic [3:0]  lane_sel;
  logic [31:0] lane_dat;
  logic [31:0] lane_rdata;
  logic        timeout;
  logic        in_bus;

  assign in_bus = (state_q == BUS);

  wb_lane_align u_lane_align (
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .dat_i      (dat_i),
    .sel_o      (lane_sel),
    .dat_o      (lane_dat),
    .rdata_o    (lane_rdata)
  );

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter sits at zero outside BUS, which is the same as clearing on entry.
  always_comb begin
    cnt_d = cnt_q;
    if (!in_bus) begin
      cnt_d = '0;
    end else if (!ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // An ack on the terminal cycle takes priority over the timeout.
  assign timeout = in_bus && !ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          we_d    = req_we_i;
          rdata_d = 32'h0;
          err_d   = is_misaligned(req_addr_i[1:0], req_size_i);
          state_d = err_d ? DONE : BUS;
        end
      end
      BUS: begin
        if (ack_i) begin
          rdata_d = we_q ? 32'h0 : lane_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign resp_err_o   = (state_q == DONE) && err_q;
  assign resp_rdata_o = rdata_q;

  assign cyc_o = in_bus;
  assign stb_o = in_bus;
  assign we_o  = in_bus && we_q;
  assign adr_o = {addr_q[31:2], 2'b00};
  assign dat_o = lane_dat;
  assign sel_o = in_bus ? lane_sel : 4'b0000;

endmodule

// File: tb/tb_wb_initiator.sv
module tb_wb_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i;

  logic        ack_en = 1'b0;
  logic        ack_force = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .cyc_o          (cyc_o),
    .stb_o          (stb_o),
    .we_o           (we_o),
    .adr_o          (adr_o),
    .dat_o          (dat_o),
    .sel_o          (sel_o),
    .dat_i          (dat_i),
    .ack_i          (ack_i)
  );

  // Responder: acks after ack_delay wait-state cycles of an active strobe.
  assign ack_i = ack_force | (ack_en & cyc_o & stb_o & (wait_cnt == ack_delay));

  always @(posedge clk) begin
    if (cyc_o && stb_o && !ack_i) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-level view of the sizing rules.
  function automatic bit m_mis(input logic [31:0] a, input int sz);
    if (sz == 3) return 1'b1;
    return (int'(a[1:0]) % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a, input int sz);
    logic [3:0] s;
    int off;
    int n;
    s = 4'b0;
    off = int'(a[1:0]);
    n = 1 << sz;
    for (int i = 0; i < n; i++) s[off + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_dat(input logic [31:0] w, input int sz);
    logic [31:0] d;
    int n;
    n = 1 << sz;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = w[8*(i % n) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] di, input logic [31:0] a,
                                          input int sz, input bit uns);
    logic [31:0] v;
    int off;
    int n;
    v = 32'h0;
    off = int'(a[1:0]);
    n = 1 << sz;
    for (int i = 0; i < n; i++) v[8*i +: 8] = di[8*(off + i) +: 8];
    if (!uns && v[8*n - 1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic do_txn(input string tag, input bit we, input logic [31:0] a, input int sz,
                        input bit uns, input logic [31:0] wd, input logic [31:0] di,
                        input int dly);
    logic [31:0] exp_rd;
    @(negedge clk);
    check({tag, ".ready_pre"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_addr_i     = a;
    req_size_i     = 2'(sz);
    req_unsigned_i = uns;
    req_wdata_i    = wd;
    dat_i          = di;
    ack_delay      = dly;
    ack_en         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    if (m_mis(a, sz)) begin
      check({tag, ".mis_cyc"},   {31'b0, cyc_o}, 32'd0);
      check({tag, ".mis_sel"},   {28'b0, sel_o}, 32'd0);
      check({tag, ".mis_valid"}, {31'b0, resp_valid_o}, 32'd1);
      check({tag, ".mis_err"},   {31'b0, resp_err_o}, 32'd1);
      check({tag, ".mis_rdata"}, resp_rdata_o, 32'd0);
    end else begin
      for (int k = 0; k <= dly; k++) begin
        if (k > 0) @(negedge clk);
        check({tag, ".cyc"},   {30'b0, cyc_o, stb_o}, 32'd3);
        check({tag, ".ready"}, {30'b0, req_ready_o, resp_valid_o}, 32'd0);
        check({tag, ".adr"},   adr_o, a & 32'hFFFF_FFFC);
        check({tag, ".sel"},   {28'b0, sel_o}, {28'b0, m_sel(a, sz)});
        check({tag, ".we"},    {31'b0, we_o}, {31'b0, we});
        if (we) check({tag, ".dat"}, dat_o, m_dat(wd, sz));
      end
      @(negedge clk);
      exp_rd = we ? 32'h0 : m_rdata(di, a, sz, uns);
      check({tag, ".cyc_drop"}, {31'b0, cyc_o}, 32'd0);
      check({tag, ".valid"},    {31'b0, resp_valid_o}, 32'd1);
      check({tag, ".err"},      {31'b0, resp_err_o}, 32'd0);
      check({tag, ".rdata"},    resp_rdata_o, exp_rd);
    end
    @(negedge clk);
    check({tag, ".post"}, {30'b0, resp_valid_o, req_ready_o}, 32'd1);
  endtask

  task automatic start_read(input logic [31:0] a);
    @(negedge clk);
    ack_en         = 1'b0;
    req_valid_i    = 1'b1;
    req_we_i       = 1'b0;
    req_addr_i     = a;
    req_size_i     = 2'd2;
    req_unsigned_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  initial begin
    int held;
    int stray;
    int sz;
    logic [31:0] a;

    rst_n = 1'b0;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_addr_i = 32'h0;
    req_wdata_i = 32'h0;
    req_size_i = 2'd0;
    req_unsigned_i = 1'b0;
    dat_i = 32'h0;
    repeat (3) @(negedge clk);
    check("rst.ctl", {26'b0, cyc_o, stb_o, we_o, resp_valid_o, resp_err_o, req_ready_o}, 32'd1);
    check("rst.adr", adr_o, 32'd0);
    check("rst.dat", dat_o, 32'd0);
    check("rst.rdata", resp_rdata_o, 32'd0);
    check("rst.sel", {28'b0, sel_o}, 32'd0);
    rst_n = 1'b1;

    do_txn("wr_word", 1'b1, 32'h1000_0004, 2, 1'b0, 32'hDEADBEEF, 32'h0, 0);
    do_txn("rd_byte_s", 1'b0, 32'h1000_0003, 0, 1'b0, 32'h0, 32'h8000_0000, 0);
    do_txn("rd_byte_u", 1'b0, 32'h1000_0003, 0, 1'b1, 32'h0, 32'h8000_0000, 0);
    do_txn("wr_half", 1'b1, 32'h1000_0002, 1, 1'b0, 32'h0000_1234, 32'h0, 1);
    do_txn("rd_half_mis", 1'b0, 32'h1000_0001, 1, 1'b0, 32'h0, 32'hFFFF_FFFF, 0);
    do_txn("rd_sz3", 1'b0, 32'h1000_0000, 3, 1'b0, 32'h0, 32'hFFFF_FFFF, 0);
    do_txn("rd_delay5", 1'b0, 32'h2000_0000, 2, 1'b0, 32'h0, 32'hCAFE_F00D, 5);

    // Ack while idle must not produce a response.
    @(negedge clk);
    ack_force = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid_o || cyc_o || !req_ready_o) stray++;
    end
    ack_force = 1'b0;
    check("idle_ack", stray, 0);

    for (int t = 0; t < 40; t++) begin
      sz = int'($urandom_range(0, 3));
      a = $urandom;
      do_txn("rand", 1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
             $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    start_read(32'h3000_0010);
`ifdef WB_TIMEOUT_EN
    held = 0;
    for (int k = 0; k < TO; k++) begin
      if (k > 0) @(negedge clk);
      if (cyc_o && stb_o && !resp_valid_o) held++;
    end
    check("to.held", held, TO);
    @(negedge clk);
    check("to.drop", {30'b0, cyc_o, stb_o}, 32'd0);
    check("to.resp", {30'b0, resp_valid_o, resp_err_o}, 32'd3);
    check("to.rdata", resp_rdata_o, 32'd0);
    @(negedge clk);
    check("to.post", {31'b0, req_ready_o}, 32'd1);
    start_read(32'h3000_0020);
    repeat (2) @(negedge clk);
`else
    held = 0;
    for (int k = 0; k < 120; k++) begin
      if (k > 0) @(negedge clk);
      if (cyc_o && stb_o && !resp_valid_o && !req_ready_o) held++;
    end
    check("hold.cyc", held, 120);
`endif

    // Reset while BUS is active.
    check("rst_bus.pre", {31'b0, cyc_o}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_bus.cyc", {30'b0, cyc_o, stb_o}, 32'd0);
    check("rst_bus.valid", {31'b0, resp_valid_o}, 32'd0);
    rst_n = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid_o || cyc_o) stray++;
    end
    check("rst_bus.quiet", stray, 0);
    do_txn("after_rst", 1'b0, 32'h1000_0006, 1, 1'b0, 32'h0, 32'h8001_0000, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
